// File: rtl/adc_window_averager_if.sv
// Stream bundle for the ADC window averager.
//   in_valid / in_data              : one raw ADC code per strobe, no backpressure
//   out_valid / out_ready           : result queue head handshake
//   out_data / out_min / out_max    : rounded window average, window min, window max
// Modports:
//   master : the side that produces codes and consumes results (ADC + consumer)
//   slave  : the averager itself
interface adc_window_averager_if #(
    parameter int DATA_W = 7
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] out_min;
    logic [DATA_W-1:0] out_max;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_min, out_max
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_min, out_max
    );
endinterface

// File: rtl/adc_window_averager.sv
// Boxcar averager behind the ramp-compare ADC. Accumulates 2^LOG2_AVG codes,
// then pushes {rounded average, window min, window max} into a 2-entry queue.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   bus (slave)    : in_valid/in_data input strobe, out_* result handshake
//   overrun_count  : windows dropped because the queue was full (saturates at 255)
//   clear_stats    : 1-cycle pulse zeroing overrun_count
module adc_window_averager #(
    parameter int DATA_W   = 7,
    parameter int LOG2_AVG = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    adc_window_averager_if.slave  bus,
    output logic [7:0]            overrun_count,
    input  logic                  clear_stats
);
    localparam int ACC_W = DATA_W + LOG2_AVG;
    // LOG2_AVG=0 still needs a 1-bit counter; it simply never leaves 0.
    localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << LOG2_AVG) - 1);
    localparam logic [ACC_W-1:0] RND     = (LOG2_AVG == 0) ? '0 : ACC_W'(1 << (LOG2_AVG - 1));

    typedef struct packed {
        logic [DATA_W-1:0] avg;
        logic [DATA_W-1:0] mn;
        logic [DATA_W-1:0] mx;
    } result_t;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] min_q, min_d, max_q, max_d;
    result_t           head_q, head_d, tail_q, tail_d;
    logic [1:0]        count_q, count_d;
    logic [7:0]        ovr_q, ovr_d;

    logic [DATA_W-1:0] min_cur, max_cur;
    logic [ACC_W-1:0]  sum, rsum;
    logic              push, pop, overrun;
    result_t           new_res;
    logic              unused_rsum;

    // Sum never exceeds 2^ACC_W - 2^LOG2_AVG, so adding the half-LSB
    // rounding term cannot carry out of ACC_W bits.
    assign sum         = acc_q + ACC_W'(bus.in_data);
    assign rsum        = sum + RND;
    assign unused_rsum = ^rsum;
    assign min_cur     = (bus.in_data < min_q) ? bus.in_data : min_q;
    assign max_cur     = (bus.in_data > max_q) ? bus.in_data : max_q;
    assign push        = bus.in_valid && (cnt_q == CNT_MAX);
    assign pop         = (count_q != 2'd0) && bus.out_ready;

    always_comb begin
        new_res.avg = rsum[ACC_W-1 -: DATA_W];
        new_res.mn  = min_cur;
        new_res.mx  = max_cur;
    end

    // Window accumulation; a closing sample restarts the window even when
    // its result ends up dropped.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        min_d = min_q;
        max_d = max_q;
        if (bus.in_valid) begin
            if (push) begin
                acc_d = '0;
                cnt_d = '0;
                min_d = '1;
                max_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
                min_d = min_cur;
                max_d = max_cur;
            end
        end
    end

    // Two-entry queue with a registered head. Pop frees a slot in the same
    // cycle, so push+pop is accepted even when full.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        overrun = 1'b0;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = new_res;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = new_res;
                end else if (pop) begin
                    count_d = 2'd0;
                end else if (push) begin
                    tail_d  = new_res;
                    count_d = 2'd2;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push) tail_d  = new_res;
                    else      count_d = 2'd1;
                end else if (push) begin
                    overrun = 1'b1;
                end
            end
        endcase
    end

    // Clear wins over increment, but an overrun in the clearing cycle still counts.
    always_comb begin
        ovr_d = ovr_q;
        if (clear_stats)
            ovr_d = {7'd0, overrun};
        else if (overrun && ovr_q != 8'hFF)
            ovr_d = ovr_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            min_q   <= '1;
            max_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            ovr_q   <= 8'd0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            min_q   <= min_d;
            max_q   <= max_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_data  = head_q.avg;
    assign bus.out_min   = head_q.mn;
    assign bus.out_max   = head_q.mx;
    assign overrun_count = ovr_q;
endmodule

// File: tb/tb_adc_window_averager.sv
// Bench for adc_window_averager (DATA_W=7, LOG2_AVG=4). Directed scenarios
// followed by random traffic, all checked every cycle against a window/queue
// reference model plus constant expectations at key points.
module tb_adc_window_averager;
    localparam int DATA_W = 7;
    localparam int WIN    = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear_stats;
    logic [7:0] overrun_count;

    adc_window_averager_if #(.DATA_W(DATA_W)) bus ();

    adc_window_averager #(.DATA_W(DATA_W), .LOG2_AVG(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .overrun_count (overrun_count),
        .clear_stats   (clear_stats)
    );

    always #5 clk = ~clk;

    typedef struct {
        int avg;
        int mn;
        int mx;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    int   win[$];
    res_t exp_q[$];
    int   m_ovr = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, update model at posedge, check at next negedge.
    task automatic step(bit v, int d, bit rdy, bit clr, bit r = 1'b0);
        logic [31:0] dv;
        bit   pop;
        bit   push;
        bit   ovf;
        int   sum;
        res_t nr;
        dv = d;
        reset           = r;
        bus.in_valid    = v;
        bus.in_data     = dv[DATA_W-1:0];
        bus.out_ready   = rdy;
        clear_stats     = clr;
        @(posedge clk);
        push = 1'b0;
        ovf  = 1'b0;
        nr   = '{0, 0, 0};
        if (r) begin
            win.delete();
            exp_q.delete();
            m_ovr = 0;
        end else begin
            pop = (exp_q.size() > 0) && rdy;
            if (v) begin
                win.push_back(d);
                if (win.size() == WIN) begin
                    sum = 0; nr.mn = 1 << DATA_W; nr.mx = -1;
                    foreach (win[i]) begin
                        sum += win[i];
                        if (win[i] < nr.mn) nr.mn = win[i];
                        if (win[i] > nr.mx) nr.mx = win[i];
                    end
                    nr.avg = (sum + WIN / 2) / WIN;
                    push = 1'b1;
                    win.delete();
                end
            end
            if (pop) void'(exp_q.pop_front());
            if (push) begin
                if (exp_q.size() < 2) exp_q.push_back(nr);
                else                  ovf = 1'b1;
            end
            if (clr)                    m_ovr = ovf ? 1 : 0;
            else if (ovf && m_ovr < 255) m_ovr++;
        end
        @(negedge clk);
        chk("out_valid", bus.out_valid, (exp_q.size() > 0) ? 1 : 0);
        chk("overrun_count", overrun_count, m_ovr);
        if (exp_q.size() > 0) begin
            chk("out_data", bus.out_data, exp_q[0].avg);
            chk("out_min",  bus.out_min,  exp_q[0].mn);
            chk("out_max",  bus.out_max,  exp_q[0].mx);
        end
        if (r) begin
            chk("rst_out_data", bus.out_data, 0);
            chk("rst_out_min",  bus.out_min,  0);
            chk("rst_out_max",  bus.out_max,  0);
        end
    endtask

    task automatic feed(int code, int n, bit rdy, bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom % 3 == 0)) step(0, 0, rdy, 0);
            step(1, code, rdy, 0);
        end
    endtask

    task automatic head_is(string tag, int d, int mn, int mx);
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_data"},  bus.out_data,  d);
        chk({tag, "_min"},   bus.out_min,   mn);
        chk({tag, "_max"},   bus.out_max,   mx);
    endtask

    initial begin
        reset = 1'b1; clear_stats = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        @(negedge clk);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("reset_ovr", overrun_count, 0);

        // Constant code window
        feed(10, 16, 0, 1);
        head_is("t1", 10, 10, 10);
        step(0, 0, 1, 0);
        chk("t1_empty", bus.out_valid, 0);

        // Half rounds up: 56/16 = 3.5 -> 4
        feed(3, 8, 0, 1);
        feed(4, 8, 0, 1);
        head_is("t2", 4, 3, 4);
        step(0, 0, 1, 0);

        // Extremes: no wrap at full scale
        feed(127, 16, 0, 0);
        head_is("t3_max", 127, 127, 127);
        step(0, 0, 1, 0);
        feed(0, 16, 0, 0);
        head_is("t3_zero", 0, 0, 0);
        step(0, 0, 1, 0);

        // Three windows with consumer stalled: third dropped
        feed(5, 16, 0, 1);
        feed(6, 16, 0, 1);
        feed(7, 16, 0, 1);
        chk("t4_ovr", overrun_count, 1);
        head_is("t4_first", 5, 5, 5);
        step(0, 0, 1, 0);
        head_is("t4_second", 6, 6, 6);
        step(0, 0, 1, 0);
        chk("t4_empty", bus.out_valid, 0);

        // Full queue, close coincides with pop -> accepted
        feed(1, 16, 0, 0);
        feed(2, 16, 0, 0);
        feed(9, 15, 0, 0);
        step(1, 9, 1, 0);
        chk("t5_ovr", overrun_count, 1);
        head_is("t5_head", 2, 2, 2);

        // clear_stats alone, then clear coinciding with an overrun
        step(0, 0, 0, 1);
        chk("clr_zero", overrun_count, 0);
        feed(11, 15, 0, 0);
        step(1, 11, 0, 1);
        chk("clr_with_ovr", overrun_count, 1);
        step(0, 0, 1, 0);
        head_is("t5_tail", 9, 9, 9);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);

        // Reset discards a partial window
        feed(50, 7, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("t6_rst_valid", bus.out_valid, 0);
        feed(20, 16, 0, 1);
        head_is("t6", 20, 20, 20);
        chk("t6_ovr", overrun_count, 0);
        step(0, 0, 1, 0);

        // Random traffic with stalled and free-running consumer phases
        for (int i = 0; i < 1500; i++) begin
            bit rdy;
            rdy = ((i / 100) % 2 == 1) ? ($urandom % 4 != 0) : ($urandom % 8 == 0);
            step($urandom % 2, $urandom % 128, rdy, $urandom % 64 == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
